// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences the PLL reset and lock handshake and releases sys_rst once lock is stable.
//
// Ports:
//   refclk          reference clock, all logic on its rising edge
//   rst             synchronous active-high reset
//   locked          PLL locked flag, asynchronous to refclk
//   force_relock    single-cycle request to restart the PLL
//   pll_rst         active-high reset to the PLL (high only while resetting it)
//   sys_rst         active-high reset for PLL-clocked logic (low only while running)
//   ready           high while the PLL is locked and stable
//   fail            sticky, lock never achieved within MAX_RETRIES+1 attempts
//   lock_loss_count saturating count of lock losses seen while running
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] lock_loss_count
);
    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;
    localparam int CMAX = (RST_CYCLES > LOCK_TIMEOUT) ?
                          ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) :
                          ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES);
    localparam int CW = $clog2(CMAX);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] llc_q, llc_d;
    logic [1:0]       sync_q, sync_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], locked};
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        llc_d   = llc_q;
        if (force_relock && state_q != S_FAIL) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock seen in the timeout cycle still wins
                    if (locked_s) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = (retry_q == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
                        retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
                        cnt_d   = '0;
                    end
                end
                S_SETTLE: begin
                    // a dropout restarts the lock wait without consuming a retry
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == SET_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        llc_d   = (llc_q == '1) ? llc_q : llc_q + 1'b1;
                    end
                end
                S_FAIL: cnt_d = cnt_q;
                default: begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
        // outputs are flopped from the next state so they line up with state_q
        pll_rst_d = (state_d == S_RESET_PLL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            llc_q     <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            llc_q     <= llc_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst         = sys_rst_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign lock_loss_count = llc_q;
endmodule
